// File: rtl/jtpang_dma_pkg.sv
// rtl/jtpang_dma_pkg.sv - shared state codes and widths for the object-table DMA
package jtpang_dma_pkg;

   // byte index width; wide enough for LEN+1 with the largest 4096-byte transfer
   localparam int CNTW = 13;

   typedef logic [2:0] dma_state_t;

   localparam dma_state_t IDLE    = 3'd0;
   localparam dma_state_t WAIT_VB = 3'd1;
   localparam dma_state_t REQ     = 3'd2;
   localparam dma_state_t ACK     = 3'd3;
   localparam dma_state_t COPY    = 3'd4;
   localparam dma_state_t REL     = 3'd5;

endpackage

// File: rtl/jtpang_dma.sv
// rtl/jtpang_dma.sv - object-table DMA sequencer for the Pang main board
module jtpang_dma
   import jtpang_dma_pkg::*;
#(
   parameter int          LEN      = 512,
   parameter logic [11:0] SRC_BASE = 12'h000,
   parameter int          OAW      = 9,
   parameter bit          VB_ONLY  = 1'b1,
   parameter int          TW       = 10
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           cen,
   input  logic           dma_go,
   input  logic           LVBL,
   input  logic           busak_n,
   output logic           busrq_n,
   output logic [11:0]    src_addr,
   input  logic [7:0]     src_dout,
   output logic [OAW-1:0] obj_addr,
   output logic [7:0]     obj_din,
   output logic           obj_we,
   output logic           busy,
   output logic           done,
   output logic           err
);

   // index of the final COPY tick (the one that writes byte LEN-1)
   localparam logic [CNTW-1:0] LAST_IDX = CNTW'(LEN);
   // the source address stops advancing once it points at byte LEN-1
   localparam logic [CNTW-1:0] LAST_SRC = CNTW'(LEN - 1);

   dma_state_t      state;
   logic            go_q;
   logic            go_rise;
   logic            pending;
   logic [CNTW-1:0] idx;
   logic [TW-1:0]   tcnt;
   logic [TW-1:0]   tcnt_nxt;

   assign go_rise  = dma_go & ~go_q;
   assign tcnt_nxt = tcnt + TW'(1);

   // strobe history runs on every clk so a strobe between cen ticks is not lost
   always_ff @(posedge clk) begin
      if (rst) go_q <= 1'b0;
      else     go_q <= dma_go;
   end

   // transfer sequencer: start request, bus handshake, pipelined copy, release
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busrq_n  <= 1'b1;
         src_addr <= SRC_BASE;
         obj_addr <= '0;
         obj_din  <= '0;
         obj_we   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         pending  <= 1'b0;
         tcnt     <= '0;
         idx      <= '0;
      end else begin
         obj_we <= 1'b0;
         if (go_rise) pending <= 1'b1;
         if (cen) begin
            done <= 1'b0;
            case (state)
               IDLE: begin
                  if (pending) begin
                     // a strobe landing on the accept edge stays queued
                     pending <= go_rise;
                     err     <= 1'b0;
                     busy    <= 1'b1;
                     state   <= WAIT_VB;
                  end
               end
               WAIT_VB: begin
                  if (!VB_ONLY || !LVBL) begin
                     busrq_n <= 1'b0;
                     state   <= REQ;
                  end
               end
               REQ: begin
                  busrq_n <= 1'b0;
                  tcnt    <= '0;
                  state   <= ACK;
               end
               ACK: begin
                  if (!busak_n) begin
                     src_addr <= SRC_BASE;
                     idx      <= '0;
                     state    <= COPY;
                  end else begin
                     tcnt <= tcnt_nxt;
                     if (&tcnt_nxt) begin
                        err     <= 1'b1;
                        busrq_n <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                     end
                  end
               end
               COPY: begin
                  if (busak_n) begin
                     // CPU took the bus back: stop writing and hand it over at once
                     err     <= 1'b1;
                     busrq_n <= 1'b1;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     idx <= idx + CNTW'(1);
                     if (idx < LAST_SRC) src_addr <= src_addr + 12'd1;
                     // read data trails the address by one tick, so tick k stores byte k-1
                     if (idx != '0) begin
                        obj_we   <= 1'b1;
                        obj_addr <= OAW'(idx - CNTW'(1));
                        obj_din  <= src_dout;
                     end
                     if (idx == LAST_IDX) state <= REL;
                  end
               end
               REL: begin
                  busrq_n <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtpang_dma.sv
// tb/tb_jtpang_dma.sv - scoreboard bench for the object-table DMA
`timescale 1ns/1ps
module tb_jtpang_dma;

   localparam int          LEN      = 8;
   localparam logic [11:0] SRC_BASE = 12'hFFC;
   localparam int          OAW      = 3;
   localparam int          TW       = 4;
   // cen ticks with busrq_n low before a timeout: the REQ tick plus 2^TW-1 ACK ticks
   localparam int          TO_LOW_TICKS = 1 + ((1 << TW) - 1);

   localparam int EV_WR   = 0;
   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   typedef struct {
      int         kind;
      int         addr;
      int         data;
      bit         timeout;
   } ev_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           cen;
   logic           dma_go;
   logic           LVBL;
   logic           busak_n;
   logic           busrq_n;
   logic [11:0]    src_addr;
   logic [7:0]     src_dout = 8'd0;
   logic [OAW-1:0] obj_addr;
   logic [7:0]     obj_din;
   logic           obj_we;
   logic           busy;
   logic           done;
   logic           err;

   jtpang_dma #(
      .LEN      (LEN),
      .SRC_BASE (SRC_BASE),
      .OAW      (OAW),
      .VB_ONLY  (1'b1),
      .TW       (TW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .dma_go   (dma_go),
      .LVBL     (LVBL),
      .busak_n  (busak_n),
      .busrq_n  (busrq_n),
      .src_addr (src_addr),
      .src_dout (src_dout),
      .obj_addr (obj_addr),
      .obj_din  (obj_din),
      .obj_we   (obj_we),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   ev_t  sb[$];
   logic [7:0] mem [0:4095];

   int   tick_cnt = 0;
   int   low_ticks = 0;
   bit   cen_off = 1'b0;

   int   ack_delay = 0;
   int   drop_after = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // video RAM: data appears one cen tick after the address
   always @(posedge clk) if (cen) src_dout <= mem[src_addr];

   always @(posedge clk) begin
      if (cen) tick_cnt <= tick_cnt + 1;
      if (!busy) low_ticks <= 0;
      else if (cen && !busrq_n) low_ticks <= low_ticks + 1;
   end

   initial begin
      cen = 1'b0;
      forever begin
         @(negedge clk);
         cen = cen_off ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
   end

   // Z80 stand-in: grants after ack_delay ticks (never if negative), drops after drop_after writes
   initial begin
      int  req_tick;
      int  wr_seen;
      bit  granted;
      busak_n  = 1'b1;
      req_tick = -1;
      wr_seen  = 0;
      granted  = 1'b0;
      forever begin
         @(negedge clk);
         if (busrq_n !== 1'b0) begin
            busak_n  = 1'b1;
            granted  = 1'b0;
            req_tick = -1;
            wr_seen  = 0;
         end else if (!granted) begin
            if (req_tick < 0) req_tick = tick_cnt;
            if (ack_delay >= 0 && tick_cnt - req_tick >= ack_delay) begin
               busak_n = 1'b0;
               granted = 1'b1;
            end
         end else begin
            if (obj_we === 1'b1) wr_seen++;
            if (drop_after > 0 && wr_seen == drop_after) busak_n = 1'b1;
         end
      end
   end

   // monitor: every observable event must match the head of the scoreboard
   initial begin
      ev_t e;
      bit  done_q;
      bit  err_q;
      done_q = 1'b0;
      err_q  = 1'b0;
      forever begin
         @(negedge clk);
         if (obj_we === 1'b1) begin
            check("write expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("write kind", EV_WR, e.kind);
               if (e.kind == EV_WR) begin
                  check("obj_addr", 32'(obj_addr), e.addr);
                  check("obj_din", 32'(obj_din), e.data);
               end
            end
         end
         if (done === 1'b1 && !done_q) begin
            check("done expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("done kind", EV_DONE, e.kind);
            end
            check("busrq_n at done", 32'(busrq_n), 32'd1);
            check("err at done", 32'(err), 32'd0);
            check("busy at done", 32'(busy), 32'd0);
         end
         if (err === 1'b1 && !err_q) begin
            check("err expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("err kind", EV_ERR, e.kind);
               if (e.timeout) check("timeout ticks", low_ticks, TO_LOW_TICKS);
            end
            check("busrq_n at err", 32'(busrq_n), 32'd1);
            check("done at err", 32'(done), 32'd0);
            check("busy at err", 32'(busy), 32'd0);
         end
         done_q = (done === 1'b1);
         err_q  = (err === 1'b1);
      end
   end

   task automatic tick();
      do @(posedge clk); while (cen !== 1'b1);
      #1;
   endtask

   task automatic pulse_go();
      @(negedge clk);
      dma_go = 1'b1;
      @(negedge clk);
      dma_go = 1'b0;
   endtask

   task automatic fill_window();
      for (int i = 0; i < LEN; i++) mem[(int'(SRC_BASE) + i) % 4096] = 8'($urandom);
   endtask

   // reference: bytes SRC_BASE+i (mod 4096) land at object address i (mod 2^OAW)
   task automatic expect_transfer(input bit timeout, input int drop);
      ev_t e;
      int  n;
      e.timeout = timeout;
      e.addr    = 0;
      e.data    = 0;
      if (timeout) begin
         e.kind = EV_ERR;
         sb.push_back(e);
      end else begin
         n = (drop > 0) ? drop : LEN;
         for (int i = 0; i < n; i++) begin
            e.kind = EV_WR;
            e.addr = i % (1 << OAW);
            e.data = int'(mem[(int'(SRC_BASE) + i) % 4096]);
            sb.push_back(e);
         end
         e.kind = (drop > 0) ? EV_ERR : EV_DONE;
         e.addr = 0;
         e.data = 0;
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, " drained"}, 32'(sb.size() == 0 && busy === 1'b0), 32'd1);
      if (n >= 3000) begin
         sb.delete();
         @(negedge clk); rst = 1'b1;
         @(negedge clk); rst = 1'b0;
      end
   endtask

   task automatic wait_event(input string name, input int which);
      int n;
      n = 0;
      while (((which == 0) ? obj_we : done) !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, " seen"}, 32'(n < 3000), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int hold;
      int wr_cnt;
      bit to;
      int drop;

      rst    = 1'b1;
      dma_go = 1'b0;
      LVBL   = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      repeat (4) @(negedge clk);
      check("rst busrq_n", 32'(busrq_n), 32'd1);
      check("rst src_addr", 32'(src_addr), 32'(SRC_BASE));
      check("rst obj_addr", 32'(obj_addr), 32'd0);
      check("rst obj_din", 32'(obj_din), 32'd0);
      check("rst obj_we", 32'(obj_we), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst err", 32'(err), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // plain transfer, grant three ticks after the request, source wraps past 0xFFF
      ack_delay = 3; drop_after = 0;
      fill_window();
      expect_transfer(1'b0, 0);
      pulse_go();
      wait_drain("basic");

      // outside vertical blank the bus is not requested
      ack_delay = 1;
      fill_window();
      LVBL = 1'b1;
      expect_transfer(1'b0, 0);
      pulse_go();
      repeat (6) tick();
      check("vb wait busy", 32'(busy), 32'd1);
      check("vb wait busrq_n", 32'(busrq_n), 32'd1);
      @(negedge clk);
      LVBL = 1'b0;
      tick();
      check("vb request", 32'(busrq_n), 32'd0);
      wait_drain("vblank");

      // no grant at all
      ack_delay = -1;
      expect_transfer(1'b1, 0);
      pulse_go();
      wait_drain("timeout");

      // grant lost after two bytes
      ack_delay = 2; drop_after = 2;
      fill_window();
      expect_transfer(1'b0, 2);
      pulse_go();
      wait_drain("lost grant");

      // two strobes during a copy collapse into one follow-up transfer
      ack_delay = 1; drop_after = 0;
      fill_window();
      expect_transfer(1'b0, 0);
      expect_transfer(1'b0, 0);
      pulse_go();
      wait_event("first copy write", 0);
      pulse_go();
      @(negedge clk);
      pulse_go();
      wait_event("first done", 1);
      tick();
      check("restart one tick after done", 32'(busy), 32'd1);
      wait_drain("back to back");

      // reset in the middle of a copy with cen low
      ack_delay = 0;
      fill_window();
      expect_transfer(1'b0, 0);
      pulse_go();
      wr_cnt = 0;
      for (int n = 0; n < 3000 && wr_cnt < 2; n++) begin
         @(negedge clk);
         if (obj_we === 1'b1) wr_cnt++;
      end
      check("mid copy reached", wr_cnt, 2);
      cen_off = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid rst cen", 32'(cen), 32'd0);
      check("mid rst busrq_n", 32'(busrq_n), 32'd1);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst obj_we", 32'(obj_we), 32'd0);
      check("mid rst done", 32'(done), 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      cen_off = 1'b0;
      fill_window();
      expect_transfer(1'b0, 0);
      pulse_go();
      wait_drain("after reset");

      // randomized mix of grant delays, timeouts, lost grants and blanking waits
      for (int t = 0; t < 20; t++) begin
         to   = ($urandom_range(0, 7) == 0);
         drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LEN - 1)) : 0;
         hold = int'($urandom_range(0, 4));
         ack_delay  = to ? -1 : int'($urandom_range(0, 5));
         drop_after = drop;
         fill_window();
         expect_transfer(to, drop);
         if (hold > 0) LVBL = 1'b1;
         pulse_go();
         if (hold > 0) begin
            repeat (hold) tick();
            @(negedge clk);
            LVBL = 1'b0;
         end
         wait_drain("random");
      end

      check("scoreboard empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
